// File: rtl/system_controller.sv
// Command sequencer for the grid memory: turns LOAD/RUN/OUTPUT commands into
// exact-length mode-enable windows and counts generations run since the last load.
module system_controller #(
  parameter int data_size = 64,
  parameter int gen_width = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 CMD_VALID,
  input  logic [1:0]           CMD_OP,
  input  logic [gen_width-1:0] CMD_GENS,
  output logic                 CMD_READY,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 SERIAL_OUT_VALID,
  output logic                 DONE,
  output logic [15:0]          GEN_COUNT
);

  localparam int CNT_W = $clog2(data_size + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RUN    = 2'b10,
    ST_OUTPUT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_RUN    = 2'b10,
    OP_OUTPUT = 2'b11
  } op_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic [gen_width-1:0] r_gen_left, w_gen_left_next;
  logic                 r_ready, r_load_mode, r_run_mode, r_output_mode;
  logic                 r_serial_out_valid, r_done;
  logic [15:0]          r_gen_count;
  logic                 w_accept, w_done_next, w_clear_gens;
  op_t                  w_op;

  assign w_accept = CMD_VALID && r_ready;
  assign w_op     = op_t'(CMD_OP);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_gen_left_next = r_gen_left;
    w_done_next     = 1'b0;
    w_clear_gens    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          unique case (w_op)
            OP_LOAD: begin
              w_state_next   = ST_LOAD;
              w_bit_cnt_next = CNT_W'(data_size);
              w_clear_gens   = 1'b1;
            end
            OP_OUTPUT: begin
              w_state_next   = ST_OUTPUT;
              w_bit_cnt_next = CNT_W'(data_size);
            end
            OP_RUN: begin
              // A zero-generation run completes immediately without touching the grid.
              if (CMD_GENS != '0) begin
                w_state_next    = ST_RUN;
                w_gen_left_next = CMD_GENS;
              end else begin
                w_done_next = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD, ST_OUTPUT: begin
        if (r_bit_cnt == CNT_W'(1)) begin
          w_state_next   = ST_IDLE;
          w_bit_cnt_next = '0;
          w_done_next    = 1'b1;
        end else begin
          w_bit_cnt_next = r_bit_cnt - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (r_gen_left == gen_width'(1)) begin
          w_state_next    = ST_IDLE;
          w_gen_left_next = '0;
          w_done_next     = 1'b1;
        end else begin
          w_gen_left_next = r_gen_left - gen_width'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state            <= ST_IDLE;
      r_bit_cnt          <= '0;
      r_gen_left         <= '0;
      r_ready            <= 1'b1;
      r_load_mode        <= 1'b0;
      r_run_mode         <= 1'b0;
      r_output_mode      <= 1'b0;
      r_serial_out_valid <= 1'b0;
      r_done             <= 1'b0;
      r_gen_count        <= '0;
    end else begin
      r_state            <= w_state_next;
      r_bit_cnt          <= w_bit_cnt_next;
      r_gen_left         <= w_gen_left_next;
      r_ready            <= (w_state_next == ST_IDLE);
      r_load_mode        <= (w_state_next == ST_LOAD);
      r_run_mode         <= (w_state_next == ST_RUN);
      r_output_mode      <= (w_state_next == ST_OUTPUT);
      // The memory registers its serial bit, so valid trails the shift enable by one cycle.
      r_serial_out_valid <= r_output_mode;
      r_done             <= w_done_next;
      if (w_clear_gens) begin
        r_gen_count <= '0;
      end else if (r_state == ST_RUN && r_gen_count != 16'hFFFF) begin
        r_gen_count <= r_gen_count + 16'd1;
      end
    end
  end

  assign CMD_READY        = r_ready;
  assign LOAD_MODE        = r_load_mode;
  assign RUN_MODE         = r_run_mode;
  assign OUTPUT_MODE      = r_output_mode;
  assign SERIAL_OUT_VALID = r_serial_out_valid;
  assign DONE             = r_done;
  assign GEN_COUNT        = r_gen_count;

endmodule

// File: doc/system_controller.md
SYSTEM_CONTROLLER -- requirements
Module: system_controller

Interface
REQ-001 SHALL have parameter data_size, default 64, giving grid bits per load/output transfer (matches the system memory width).
REQ-002 SHALL have parameter gen_width, default 8, giving the width of the requested generation count.
REQ-003 SHALL have CLK  input  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-005 SHALL have CMD_VALID  input  1  a command is presented.
REQ-006 SHALL have CMD_OP  input  2  00 NOP, 01 LOAD, 10 RUN, 11 OUTPUT.
REQ-007 SHALL have CMD_GENS  input  gen_width  generations to run; used only for RUN.
REQ-008 SHALL have CMD_READY  output  1  the controller can accept a command this cycle.
REQ-009 SHALL have LOAD_MODE  output  1  drives the memory serial-load enable.
REQ-010 SHALL have RUN_MODE  output  1  drives the memory grid-update enable; one generation per high cycle.
REQ-011 SHALL have OUTPUT_MODE  output  1  drives the memory serial-shift-out enable.
REQ-012 SHALL have SERIAL_OUT_VALID  output  1  the memory's registered serial output holds a valid bit this cycle.
REQ-013 SHALL have DONE  output  1  one-cycle pulse on command completion.
REQ-014 SHALL have GEN_COUNT  output  16  generations run since the last LOAD or reset.

Function
REQ-015 SHALL implement states IDLE, LOAD, RUN and OUTPUT, with IDLE the only state in which CMD_READY is high.
REQ-016 SHALL accept a command on a rising edge where CMD_VALID and CMD_READY are both high, and ignore CMD_VALID at all other times.
REQ-017 SHALL register all outputs, with the selected mode output first high in the cycle after acceptance.
REQ-018 SHALL keep at most one of LOAD_MODE, RUN_MODE and OUTPUT_MODE high in any cycle.
REQ-019 SHALL, on an accepted NOP, stay in IDLE with no mode output, no DONE pulse and no counter change.
REQ-020 SHALL, on an accepted LOAD, hold LOAD_MODE high for exactly data_size consecutive cycles, then return to IDLE.
REQ-021 SHALL clear GEN_COUNT to 0 on the rising edge that accepts a LOAD.
REQ-022 SHALL, on an accepted RUN with CMD_GENS=N>0, latch N and hold RUN_MODE high for exactly N consecutive cycles, then return to IDLE.
REQ-023 SHALL, on an accepted RUN with CMD_GENS=0, assert no RUN_MODE, pulse DONE in the cycle after acceptance and stay in IDLE.
REQ-024 SHALL increment GEN_COUNT once per RUN_MODE-high cycle and saturate at 16'hFFFF with no wrap.
REQ-025 SHALL, on an accepted OUTPUT, hold OUTPUT_MODE high for exactly data_size consecutive cycles, then return to IDLE.
REQ-026 SHALL drive SERIAL_OUT_VALID high in each cycle immediately following an OUTPUT_MODE-high cycle, giving exactly data_size cycles, one cycle behind OUTPUT_MODE.
REQ-027 SHALL use a down-counter of width clog2(data_size+1) or wider for LOAD/OUTPUT and a gen_width down-counter for RUN, loaded at acceptance, with the state exiting when the count reaches 1.
REQ-028 SHALL pulse DONE for one cycle in the first cycle after the last mode-high cycle, the same cycle CMD_READY returns high.
REQ-029 SHALL allow a new command to be accepted in the DONE cycle, giving back-to-back operation with one idle cycle between mode windows.
REQ-030 SHALL ignore changes on CMD_OP and CMD_GENS after acceptance until the next acceptance.

Reset
REQ-031 SHALL, with RESET high at a rising edge, enter IDLE and force CMD_READY=1, LOAD_MODE=0, RUN_MODE=0, OUTPUT_MODE=0, SERIAL_OUT_VALID=0, DONE=0, GEN_COUNT=0 and all counters to 0, taking priority over any command.
REQ-032 SHALL, when RESET arrives mid-operation, abort the operation with no DONE pulse, and drop mode outputs low the cycle after the reset edge.

Verification
REQ-033 SHALL cover: LOAD accepted at cycle 0 -> LOAD_MODE high cycles 1-64, DONE and CMD_READY high at cycle 65, GEN_COUNT=0.
REQ-034 SHALL cover: RUN with CMD_GENS=3 after a load -> RUN_MODE high exactly 3 cycles, GEN_COUNT=3, single DONE pulse; then RUN with CMD_GENS=0 -> no RUN_MODE, DONE the next cycle, GEN_COUNT stays 3.
REQ-035 SHALL cover: OUTPUT accepted at cycle 0 -> OUTPUT_MODE high cycles 1-64, SERIAL_OUT_VALID high cycles 2-65, DONE at cycle 65.
REQ-036 SHALL cover: CMD_VALID held high with LOAD then RUN(2) -> second command accepted at the DONE cycle, RUN_MODE high 2 cycles, and no overlap of mode outputs.
REQ-037 SHALL cover: RESET asserted for one cycle during RUN with CMD_GENS=200 at the 10th RUN_MODE cycle -> all outputs at reset values the next cycle, GEN_COUNT=0, no DONE.
REQ-038 SHALL cover: GEN_COUNT preloaded near saturation by repeated RUN(255) -> GEN_COUNT holds at 16'hFFFF and does not wrap.
